// File: rtl/inst_rom_arb.sv
// Two-port instruction ROM read arbiter: fetch (port 0) and debug/loader
// (port 1) share one combinational ROM. Grants are issued in the request
// cycle and read data returns one cycle later on the granted port.
// Ports: i_clk, i_rst_n (async, active low); i_req0/i_addr0 and
//   i_req1/i_addr1 requests; o_gnt0/1 grants; o_rvalid0/1 and o_rdata0/1
//   read returns; o_rom_ce, o_rom_addr, i_rom_inst ROM side.
// Config: define INST_ARB_RR_EN for round-robin on contention; otherwise
//   port 0 has fixed priority.

`ifndef N_INST_ADDR
`define N_INST_ADDR 32
`endif
`ifndef N_INST_DATA
`define N_INST_DATA 32
`endif
`ifndef CHIP_ENABLE
`define CHIP_ENABLE 1'b1
`endif
`ifndef CHIP_DISABLE
`define CHIP_DISABLE 1'b0
`endif

module inst_rom_arb (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_req0,
  input  logic [`N_INST_ADDR-1:0] i_addr0,
  input  logic                    i_req1,
  input  logic [`N_INST_ADDR-1:0] i_addr1,
  output logic                    o_gnt0,
  output logic                    o_gnt1,
  output logic                    o_rvalid0,
  output logic                    o_rvalid1,
  output logic [`N_INST_DATA-1:0] o_rdata0,
  output logic [`N_INST_DATA-1:0] o_rdata1,
  output logic                    o_rom_ce,
  output logic [`N_INST_ADDR-1:0] o_rom_addr,
  input  logic [`N_INST_DATA-1:0] i_rom_inst
);

`ifdef INST_ARB_RR_EN
  typedef enum logic {PRI0, PRI1} pri_t;
  pri_t pri;
`endif

  logic gnt0;
  logic gnt1;

  // Grants are gated by reset so nothing is accepted while held in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (i_rst_n) begin
`ifdef INST_ARB_RR_EN
      if (i_req0 && i_req1) begin
        gnt0 = (pri == PRI0);
        gnt1 = (pri == PRI1);
      end else begin
        gnt0 = i_req0;
        gnt1 = i_req1;
      end
`else
      gnt0 = i_req0;
      gnt1 = i_req1 && !i_req0;
`endif
    end
  end

  assign o_gnt0 = gnt0;
  assign o_gnt1 = gnt1;

  always_comb begin
    o_rom_ce   = `CHIP_DISABLE;
    o_rom_addr = '0;
    unique case (1'b1)
      gnt0: begin
        o_rom_ce   = `CHIP_ENABLE;
        o_rom_addr = i_addr0;
      end
      gnt1: begin
        o_rom_ce   = `CHIP_ENABLE;
        o_rom_addr = i_addr1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rvalid0 <= 1'b0;
      o_rvalid1 <= 1'b0;
      o_rdata0  <= '0;
      o_rdata1  <= '0;
    end else begin
      o_rvalid0 <= gnt0;
      o_rvalid1 <= gnt1;
      if (gnt0) o_rdata0 <= i_rom_inst;
      if (gnt1) o_rdata1 <= i_rom_inst;
    end
  end

`ifdef INST_ARB_RR_EN
  // Pointer always names the port that did not win last.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pri <= PRI0;
    end else begin
      unique case (pri)
        PRI0: if (gnt0) pri <= PRI1;
        PRI1: if (gnt1) pri <= PRI0;
        default: pri <= PRI0;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_inst_rom_arb.sv
// Scoreboard bench for inst_rom_arb: directed scenarios plus random
// traffic against a queue-based reference model.

`ifndef N_INST_ADDR
`define N_INST_ADDR 32
`endif
`ifndef N_INST_DATA
`define N_INST_DATA 32
`endif
`ifndef CHIP_ENABLE
`define CHIP_ENABLE 1'b1
`endif
`ifndef CHIP_DISABLE
`define CHIP_DISABLE 1'b0
`endif

module tb_inst_rom_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [31:0] addr0, addr1;
  logic        gnt0, gnt1;
  logic        rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;

  logic [31:0] rom [64];
  assign rom_inst = rom[rom_addr[7:2]];

  inst_rom_arb dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0(req0), .i_addr0(addr0),
    .i_req1(req1), .i_addr1(addr1),
    .o_gnt0(gnt0), .o_gnt1(gnt1),
    .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
    .o_rdata0(rdata0), .o_rdata1(rdata1),
    .o_rom_ce(rom_ce), .o_rom_addr(rom_addr),
    .i_rom_inst(rom_inst)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic [31:0] last0 = '0;
  logic [31:0] last1 = '0;
  // Round-robin reference: the port that should win the next tie.
  int prefer = 0;
  logic mon_en = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Model winner: -1 none, 0 or 1.
  function automatic int model_win(logic r0, logic r1);
    if (r0 && r1) begin
`ifdef INST_ARB_RR_EN
      return prefer;
`else
      return 0;
`endif
    end
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  // One request cycle: drive after posedge, check grant side at negedge,
  // and queue the expected read return.
  task automatic cycle(logic r0, logic [31:0] a0,
                       logic r1, logic [31:0] a1,
                       output int win);
    exp_t e;
    @(posedge clk);
    #1;
    req0 = r0; addr0 = a0;
    req1 = r1; addr1 = a1;
    @(negedge clk);
    win = model_win(r0, r1);
    chk("gnt0", {31'd0, gnt0}, {31'd0, win == 0});
    chk("gnt1", {31'd0, gnt1}, {31'd0, win == 1});
    chk("rom_ce", {31'd0, rom_ce},
        {31'd0, (win >= 0) ? `CHIP_ENABLE : `CHIP_DISABLE});
    chk("rom_addr", rom_addr,
        (win == 0) ? a0 : (win == 1) ? a1 : 32'd0);
    e.due = cyc + 1;
    if (win == 0) begin
      e.data = rom[a0[7:2]];
      q0.push_back(e);
      prefer = 1;
    end else if (win == 1) begin
      e.data = rom[a1[7:2]];
      q1.push_back(e);
      prefer = 0;
    end
  endtask

  // Monitor: pops on rvalid, checks latency, data and hold behaviour.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rvalid0) begin
        if (q0.size() == 0) begin
          chk("rvalid0_spurious", 32'd1, 32'd0);
        end else begin
          chk("rv0_latency", cyc, q0[0].due);
          chk("rdata0", rdata0, q0[0].data);
          last0 = q0[0].data;
          void'(q0.pop_front());
        end
      end else begin
        chk("rdata0_hold", rdata0, last0);
        if (q0.size() > 0 && q0[0].due <= cyc) begin
          chk("rvalid0_missing", 32'd0, 32'd1);
          void'(q0.pop_front());
        end
      end
      if (rvalid1) begin
        if (q1.size() == 0) begin
          chk("rvalid1_spurious", 32'd1, 32'd0);
        end else begin
          chk("rv1_latency", cyc, q1[0].due);
          chk("rdata1", rdata1, q1[0].data);
          last1 = q1[0].data;
          void'(q1.pop_front());
        end
      end else begin
        chk("rdata1_hold", rdata1, last1);
        if (q1.size() > 0 && q1[0].due <= cyc) begin
          chk("rvalid1_missing", 32'd0, 32'd1);
          void'(q1.pop_front());
        end
      end
    end
  end

  initial begin
    int w;
    int exp_seq[4];
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[2] = 32'h3401_1100;
    rst_n = 1'b0;
    req0 = 1'b1; addr0 = 32'h10;
    req1 = 1'b1; addr1 = 32'h20;

    // Reset state: requests high but nothing granted.
    #7;
    chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
    chk("rst_gnt1", {31'd0, gnt1}, 32'd0);
    chk("rst_ce", {31'd0, rom_ce}, {31'd0, `CHIP_DISABLE});
    chk("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
    chk("rst_rvalid1", {31'd0, rvalid1}, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    @(posedge clk);
    #1;
    req0 = 1'b0; req1 = 1'b0;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Contention from reset.
`ifdef INST_ARB_RR_EN
    exp_seq = '{0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 32'h4 * i, 1'b1, 32'h40 + 32'h4 * i, w);
      chk("contend_win", w, exp_seq[i]);
    end
    cycle(1'b0, 32'h0, 1'b1, 32'h14, w);
    chk("req1_alone", {31'd0, gnt1}, 32'd1);

    // Single read of word 2.
    cycle(1'b1, 32'h8, 1'b0, 32'h0, w);
    chk("single_addr", rom_addr, 32'h8);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, w);
    chk("single_data", rdata0, 32'h3401_1100);
    chk("single_rvalid", {31'd0, rvalid0}, 32'd1);

    // Idle cycle.
    cycle(1'b0, 32'h0, 1'b0, 32'h0, w);

    // Back-to-back port 0 reads.
    cycle(1'b1, 32'h0, 1'b0, 32'h0, w);
    cycle(1'b1, 32'h4, 1'b0, 32'h0, w);
    cycle(1'b1, 32'hC, 1'b0, 32'h0, w);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, w);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, w);

    // Reset mid-cycle after a port 1 grant, with its read pending.
    cycle(1'b0, 32'h0, 1'b1, 32'h1C, w);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    q0.delete(); q1.delete();
    last0 = '0; last1 = '0;
    prefer = 0;
    #1;
    chk("arst_rvalid1", {31'd0, rvalid1}, 32'd0);
    chk("arst_rdata1", rdata1, 32'd0);
    chk("arst_rdata0", rdata0, 32'd0);
    req1 = 1'b1;
    @(negedge clk);
    chk("arst_gnt1", {31'd0, gnt1}, 32'd0);
    chk("arst_ce", {31'd0, rom_ce}, {31'd0, `CHIP_DISABLE});
    @(posedge clk);
    #1;
    req1 = 1'b0;
    rst_n = 1'b1;
    cycle(1'b1, 32'h24, 1'b1, 32'h28, w);
    chk("post_rst_win", w, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom,
            1'($urandom_range(0, 1)), $urandom, w);
    end

    // Drain.
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0, 32'h0, w);
    chk("q0_empty", q0.size(), 32'd0);
    chk("q1_empty", q1.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
